// File: rtl/decrypt_engine_if.sv
// Handshake and data bus of the AES-128 decrypt engine.
// The master side loads the key, sequences the engine and streams ciphertext in.
interface decrypt_engine_if;
  logic         set_key;
  logic [127:0] key;
  logic         start;
  logic         halt;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state;
  logic [127:0] out;
  logic         out_valid;

  modport master (
    output set_key, key, start, halt, in_valid, state,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  set_key, key, start, halt, in_valid, state,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/decrypt_engine.sv
// Fully pipelined AES-128 inverse cipher: expands the 11 round keys once,
// then accepts one ciphertext block per cycle with an 11-edge latency.
//
// state   | meaning
// INIT    | idle, waiting for set_key to latch rk0
// READY   | key latched, waiting for start
// KEY_GEN | one round key per cycle, rk1..rk10
// PROCESS | round keys static, in_ready=1, pipeline accepting
module decrypt_engine (
  input logic clk,
  input logic rst,
  decrypt_engine_if.slave bus
);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    READY   = 2'd1,
    KEY_GEN = 2'd2,
    PROCESS = 2'd3
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] x);
    logic [127:0] y;
    int src;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      y[127-8*i -: 8] = INV_SBOX[x[127-8*src -: 8]];
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      y[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      y[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      y[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return y;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = prev[31:0];
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   key_idx;
  logic [127:0] rk [11];
  logic [127:0] rk_prev, rk_next;
  logic [127:0] s_q [10];
  logic [9:0]   v_q;
  logic [127:0] out_q;
  logic         out_valid_q;
  logic         in_ready, accept, halt_act;

  assign in_ready = (fsm_q == PROCESS);
  assign halt_act = bus.halt && (fsm_q == KEY_GEN || fsm_q == PROCESS);
  assign accept   = bus.in_valid && in_ready && !bus.halt;

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= INIT;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      INIT:    if (bus.set_key) fsm_d = READY;
      READY:   if (bus.start) fsm_d = KEY_GEN;
      KEY_GEN: begin
        if (bus.halt)              fsm_d = INIT;
        else if (key_idx == 4'd10) fsm_d = PROCESS;
      end
      PROCESS: if (bus.halt) fsm_d = INIT;
      default: fsm_d = INIT;
    endcase
  end

  always_comb begin
    rk_prev = rk[0];
    for (int i = 1; i < 10; i++)
      if (key_idx == 4'(i + 1)) rk_prev = rk[i];
  end

  assign rk_next = key_expand(rk_prev, rcon_of(key_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_idx <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      if (fsm_q == INIT && bus.set_key) rk[0] <= bus.key;
      if (fsm_q == READY && bus.start) begin
        key_idx <= 4'd1;
      end else if (fsm_q == KEY_GEN && !bus.halt) begin
        for (int i = 1; i < 11; i++)
          if (key_idx == 4'(i)) rk[i] <= rk_next;
        key_idx <= key_idx + 4'd1;
      end
    end
  end

  // Stage r applies round key rk(10-r); InvMixColumns follows AddRoundKey.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) s_q[i] <= '0;
      v_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      v_q         <= halt_act ? 10'd0 : {v_q[8:0], accept};
      out_valid_q <= v_q[9] && !halt_act;
      if (accept) s_q[0] <= bus.state ^ rk[10];
      for (int r = 1; r < 10; r++)
        if (v_q[r-1]) s_q[r] <= inv_mix(inv_shift_sub(s_q[r-1]) ^ rk[10-r]);
      if (v_q[9] && !halt_act) out_q <= inv_shift_sub(s_q[9]) ^ rk[0];
    end
  end

endmodule

// File: tb/tb_decrypt_engine.sv
// Self-checking bench for decrypt_engine: a forward AES-128 model built from
// GF(2^8) arithmetic encrypts random plaintexts, the DUT must recover them.
module tb_decrypt_engine;

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_K0 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decrypt_engine_if bus ();
  decrypt_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ov_count = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           ocyc_q [$];
  logic [7:0]   sbox_m [256];
  logic [127:0] mrk [11];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] b, inv;
    for (int v = 0; v < 256; v++) begin
      b = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gm(inv, b);
      end
      sbox_m[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ mrk[0][127-8*(r+4*c) -: 8];
    for (int n = 1; n <= 10; n++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbox_m[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = t[r][(c+r)%4];
      if (n < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[3][c] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= mrk[n][127-8*(r+4*c) -: 8];
    end
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) y[127-8*(r+4*c) -: 8] = s[r][c];
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_count++;
      ocyc_q.push_back(cyc);
      chk("out_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        chk("out_data", bus.out, exp_q[0]);
        chk("out_latency", 128'(cyc - acc_q[0]), 128'd10);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
  end

  task automatic drive(input logic valid, input logic [127:0] ct, input logic [127:0] pt);
    bus.in_valid = valid;
    bus.state    = ct;
    if (valid && bus.in_ready && !bus.halt) begin
      exp_q.push_back(pt);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.set_key = 1'b1;
    bus.key     = k;
    idle(1);
    bus.set_key = 1'b0;
    expand_model(k);
  endtask

  task automatic start_kg();
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic do_halt();
    bus.halt = 1'b1;
    exp_q.delete();
    acc_q.delete();
    idle(1);
    bus.halt = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      idle(1);
      n++;
    end
    chk("ready_reached", 128'(bus.in_ready), 128'd1);
  endtask

  task automatic send_rand(input int n, input bit gaps);
    logic [127:0] pt;
    logic v;
    for (int i = 0; i < n; i++) begin
      pt = rand128();
      v  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(v, enc(pt), pt);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      idle(1);
      k++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base, span, k;
    logic [127:0] pt, ct;
    init_sbox();
    bus.set_key = 1'b0; bus.key = '0; bus.start = 1'b0; bus.halt = 1'b0;
    bus.in_valid = 1'b0; bus.state = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", bus.out, '0);
    chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset_in_ready", 128'(bus.in_ready), 128'd0);
    chk("reset_fsm", 128'(dut.fsm_q), 128'd0);
    chk("reset_rk10", dut.rk[10], '0);
    rst = 1'b0;
    idle(1);

    // set_key together with start: only set_key acts
    bus.set_key = 1'b1; bus.key = K0; bus.start = 1'b1;
    idle(1);
    bus.set_key = 1'b0; bus.start = 1'b0;
    expand_model(K0);
    idle(12);
    chk("setkey_start_in_ready", 128'(bus.in_ready), 128'd0);
    chk("setkey_start_fsm", 128'(dut.fsm_q), 128'd1);
    bus.set_key = 1'b1; bus.key = K1;
    idle(1);
    bus.set_key = 1'b0;
    chk("ready_setkey_ignored", dut.rk[0], K0);
    start_kg();
    wait_ready(n);
    chk("keygen_cycles", 128'(n), 128'd10);
    chk("rk10_k0", dut.rk[10], RK10_K0);
    drive(1'b1, CT0, PT0);
    bus.in_valid = 1'b0;
    send_rand(10, 1'b1);
    drain();

    // halt, rekey, in_valid held from READY through KEY_GEN
    do_halt();
    chk("halt_fsm_init", 128'(dut.fsm_q), 128'd0);
    chk("halt_rk0_kept", dut.rk[0], K0);
    load_key(K1);
    bus.start = 1'b1;
    drive(1'b1, CT1, PT1);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("gate_keygen", 128'(bus.in_ready), 128'd0);
      drive(1'b1, CT1, PT1);
    end
    chk("first_process_ready", 128'(bus.in_ready), 128'd1);
    drive(1'b1, CT1, PT1);
    bus.in_valid = 1'b0;
    send_rand(8, 1'b1);
    drain();

    // zero key streaming, alternating the all-zero vector with random blocks
    do_halt();
    load_key('0);
    start_kg();
    wait_ready(n);
    ocyc_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        drive(1'b1, CTZ, '0);
      end else begin
        pt = rand128();
        drive(1'b1, enc(pt), pt);
      end
    end
    bus.in_valid = 1'b0;
    drain();
    chk("stream_count", 128'(ocyc_q.size()), 128'd12);
    span = (ocyc_q.size() > 0) ? ocyc_q[ocyc_q.size()-1] - ocyc_q[0] : -1;
    chk("stream_span", 128'(span), 128'd11);

    // halt with three blocks in flight
    send_rand(3, 1'b0);
    idle(4);
    base = ov_count;
    do_halt();
    idle(20);
    chk("halt_no_out", 128'(ov_count), 128'(base));
    chk("halt_mid_fsm", 128'(dut.fsm_q), 128'd0);
    start_kg();
    idle(14);
    chk("start_ignored_init", 128'(bus.in_ready), 128'd0);
    load_key(rand128());
    start_kg();
    wait_ready(n);
    send_rand(16, 1'b1);
    drain();

    // async reset during KEY_GEN
    do_halt();
    load_key(K1);
    start_kg();
    idle(4);
    #2 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("rst_kg_out", bus.out, '0);
    chk("rst_kg_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_kg_in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("rst_kg_rk0", dut.rk[0], '0);
    start_kg();
    idle(14);
    chk("start_needs_key", 128'(bus.in_ready), 128'd0);

    // async reset with blocks in flight and out_valid high
    load_key(K1);
    start_kg();
    wait_ready(n);
    send_rand(12, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 30) begin
      idle(1);
      k++;
    end
    chk("stream_out_seen", 128'(bus.out_valid), 128'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("rst_flight_out", bus.out, '0);
    chk("rst_flight_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_flight_in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    base = ov_count;
    idle(20);
    chk("rst_flight_no_out", 128'(ov_count), 128'(base));
    chk("rst_flight_fsm", 128'(dut.fsm_q), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
